icache_direct: RTL
==================

Name: icache_direct

Overview:
- Read-only, direct-mapped instruction cache between the instruction-fetch unit and the memory controller's i-cache port.
- One 32-bit word per line.
- Hits return in one cycle. Misses issue a single word fetch to the memory controller, fill the line, and forward the word.
- A flush input drops any in-flight delivery after a misprediction, without corrupting the memory handshake.

Parameters:
- INDEX_BITS, 8, log2 of line count (256 lines); index = addr[INDEX_BITS+1:2], tag = addr[31:INDEX_BITS+2].

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- rdy  in  1  global ready; low freezes all state and outputs
- clear  in  1  flush pulse from ROB/branch resolution
- if_req  in  1  fetch request from IF unit, held until if_valid or clear
- if_addr  in  32  fetch PC; bits [1:0] ignored
- if_valid  out  1  one-cycle pulse: if_inst is valid for the latched request
- if_inst  out  32  instruction word
- mem_fetch_enable  out  1  request to memory controller
- mem_addr  out  32  word-aligned fetch address
- mem_valid  in  1  one-cycle pulse from memory controller: mem_data valid
- mem_data  in  32  fetched word, little-endian assembled

Behaviour:
- Reset:
  - state=IDLE, if_valid=0, if_inst=0, mem_fetch_enable=0, mem_addr=0, drop=0.
  - All line valid bits are cleared. Tag and data arrays are not reset.
- rdy=0: no register changes. A mem_valid pulse during rdy=0 cannot occur, because the controller is frozen by the same rdy.
- if_valid is registered and pulses for exactly one cycle per delivered request.
- IDLE, clear=1: ignore if_req; stay IDLE; if_valid=0.
- IDLE, if_req=1, hit (valid[idx] && tag match):
  - Next edge: if_valid=1, if_inst=data[idx]; stay IDLE.
  - Hit latency is 1 cycle.
  - A back-to-back request is accepted in the cycle if_valid is high only if the IF unit presents a new address. The IF unit drops if_req in the cycle it sees if_valid unless it issues a new PC.
- IDLE, if_req=1, miss:
  - Next edge: mem_fetch_enable=1, mem_addr={if_addr[31:2],2'b00}; latch idx and tag; state=MISS; drop=0.
- MISS:
  - mem_fetch_enable and mem_addr are held stable until mem_valid, even if clear arrives. The controller cannot abort a started fetch, and its FETCH state ignores fetch_enable.
- MISS, clear=1: drop<=1; if_req is ignored for the rest of the miss.
- MISS, mem_valid=1 (next edge):
  - Write data[idx]=mem_data, tag[idx]=latched tag, valid[idx]=1.
  - mem_fetch_enable=0; state=IDLE.
  - if_valid=1 and if_inst=mem_data unless drop is set or clear is high in this same cycle; drop<=0.
  - The fill always happens; the data is correct for that address.
- Miss latency: if_valid one cycle after mem_valid.
- mem_fetch_enable must fall on the edge after mem_valid. The controller spends one STALL cycle before re-sampling fetch_enable in IDLE, so no duplicate fetch is issued.
- In IDLE and MISS, if_valid is forced to 0 on every edge except the delivery edges defined above.
- Conflict: a fill overwrites the line unconditionally (no replacement choice).
- Reset mid-MISS: return to IDLE with all valid bits 0. The controller is reset by the same rst, so no stale mem_valid is expected.
- The cache never issues stores. Self-modifying code is out of scope.

Decomposition:
- Shared constants header (`const_def.v`): ICACHE_IDLE / ICACHE_MISS state encodings and the default INDEX_BITS.
- One sub-module, icache_array:
  - Holds the valid/tag/data storage.
  - Combinational read port: hit, rdata.
  - Synchronous write port: we, widx, wtag, wdata.
  - Clears valid on rst.
- icache_direct keeps the FSM and the handshake registers.

Test Plan:
1. Cold miss: after reset, if_req=1, if_addr=0x0000_1004. Required: mem_fetch_enable=1 with mem_addr=0x0000_1004 one cycle later. Bench returns mem_valid with mem_data=0x00A0_0093. Required: if_valid=1, if_inst=0x00A0_0093 on the next cycle, mem_fetch_enable=0 on the same edge.
2. Hit: repeat if_addr=0x0000_1006 (low bits ignored). Required: if_valid one cycle later, if_inst=0x00A0_0093, mem_fetch_enable stays 0.
3. Conflict: request 0x0000_1404 (same index 0x01, different tag) -> miss, fill 0x1234_5678. Required: a following request to 0x0000_1004 misses again.
4. Flush during miss: miss on 0x0000_2000, assert clear two cycles later, mem_valid with 0xDEAD_BEEF. Required: no if_valid, mem_fetch_enable held until mem_valid. A later request to 0x0000_2000 hits and returns 0xDEAD_BEEF.
5. rdy stall: drop rdy for 3 cycles mid-MISS. Required: mem_fetch_enable, mem_addr and the state are unchanged, and delivery resumes after rdy returns.
6. Reset mid-miss: assert rst during MISS. Required: mem_fetch_enable=0, if_valid=0, and a request to the previously filled 0x0000_1004 misses.

Source files
------------

// File: rtl/icache_direct_pkg.sv
// Shared constants for the direct-mapped instruction cache: state encodings,
// default geometry and the word-align helper.
`timescale 1ns/1ps
package icache_direct_pkg;

  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned INDEX_BITS_DEF = 8;

  typedef enum logic {
    ICACHE_IDLE = 1'b0,
    ICACHE_MISS = 1'b1
  } icache_state_e;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the direct-mapped i-cache: combinational lookup,
// synchronous single-line fill, valid bits cleared on reset.
`timescale 1ns/1ps
module icache_array
  import icache_direct_pkg::*;
#(
  parameter int unsigned INDEX_BITS = INDEX_BITS_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [INDEX_BITS-1:0]      ridx_i,
  input  logic [ADDR_W-INDEX_BITS-3:0] rtag_i,
  output logic                       hit_o,
  output logic [DATA_W-1:0]          rdata_o,
  input  logic                       we_i,
  input  logic [INDEX_BITS-1:0]      widx_i,
  input  logic [ADDR_W-INDEX_BITS-3:0] wtag_i,
  input  logic [DATA_W-1:0]          wdata_i
);

  localparam int unsigned LINES    = 1 << INDEX_BITS;
  localparam int unsigned TAG_BITS = ADDR_W - INDEX_BITS - 2;

  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [DATA_W-1:0]   data_q [LINES];

  // Only the valid bits need a reset; tag/data are qualified by them.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[widx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[widx_i]  <= wtag_i;
      data_q[widx_i] <= wdata_i;
    end
  end

  assign hit_o   = valid_q[ridx_i] && (tag_q[ridx_i] == rtag_i);
  assign rdata_o = data_q[ridx_i];

endmodule

// File: rtl/icache_direct.sv
// Read-only direct-mapped instruction cache: one-cycle hits, single-word
// miss fetch from the memory controller, flush drops delivery but never the fill.
`timescale 1ns/1ps
module icache_direct
  import icache_direct_pkg::*;
#(
  parameter int unsigned INDEX_BITS = INDEX_BITS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_inst,
  output logic              mem_fetch_enable,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_data
);

  localparam int unsigned TAG_BITS = ADDR_W - INDEX_BITS - 2;

  icache_state_e         state_q, state_d;
  logic                  if_valid_q, if_valid_d;
  logic [DATA_W-1:0]     if_inst_q, if_inst_d;
  logic                  fetch_en_q, fetch_en_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic                  drop_q, drop_d;
  logic [INDEX_BITS-1:0] miss_idx_q, miss_idx_d;
  logic [TAG_BITS-1:0]   miss_tag_q, miss_tag_d;

  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic                  hit;
  logic [DATA_W-1:0]     rdata;
  logic                  fill_we;
  logic                  unused_addr_bits;

  assign req_idx          = if_addr[INDEX_BITS+1:2];
  assign req_tag          = if_addr[ADDR_W-1:INDEX_BITS+2];
  assign unused_addr_bits = ^if_addr[1:0];

  // The fill is unconditional once the word arrives, flushed or not.
  assign fill_we = rdy && (state_q == ICACHE_MISS) && mem_valid;

  icache_array #(
    .INDEX_BITS(INDEX_BITS)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .ridx_i  (req_idx),
    .rtag_i  (req_tag),
    .hit_o   (hit),
    .rdata_o (rdata),
    .we_i    (fill_we),
    .widx_i  (miss_idx_q),
    .wtag_i  (miss_tag_q),
    .wdata_i (mem_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ICACHE_IDLE;
      if_valid_q <= 1'b0;
      if_inst_q  <= '0;
      fetch_en_q <= 1'b0;
      mem_addr_q <= '0;
      drop_q     <= 1'b0;
      miss_idx_q <= '0;
      miss_tag_q <= '0;
    end else if (rdy) begin
      state_q    <= state_d;
      if_valid_q <= if_valid_d;
      if_inst_q  <= if_inst_d;
      fetch_en_q <= fetch_en_d;
      mem_addr_q <= mem_addr_d;
      drop_q     <= drop_d;
      miss_idx_q <= miss_idx_d;
      miss_tag_q <= miss_tag_d;
    end
  end

  // Next-state: if_valid defaults low so it can only pulse on delivery edges.
  always_comb begin
    state_d    = state_q;
    if_valid_d = 1'b0;
    if_inst_d  = if_inst_q;
    fetch_en_d = fetch_en_q;
    mem_addr_d = mem_addr_q;
    drop_d     = drop_q;
    miss_idx_d = miss_idx_q;
    miss_tag_d = miss_tag_q;

    case (state_q)
      ICACHE_IDLE: begin
        if (!clear && if_req) begin
          if (hit) begin
            if_valid_d = 1'b1;
            if_inst_d  = rdata;
          end else begin
            fetch_en_d = 1'b1;
            mem_addr_d = word_addr(if_addr);
            miss_idx_d = req_idx;
            miss_tag_d = req_tag;
            drop_d     = 1'b0;
            state_d    = ICACHE_MISS;
          end
        end
      end
      ICACHE_MISS: begin
        // Request stays asserted until the word returns; the controller cannot abort.
        if (mem_valid) begin
          fetch_en_d = 1'b0;
          drop_d     = 1'b0;
          state_d    = ICACHE_IDLE;
          if (!drop_q && !clear) begin
            if_valid_d = 1'b1;
            if_inst_d  = mem_data;
          end
        end else if (clear) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = ICACHE_IDLE;
    endcase
  end

  assign if_valid         = if_valid_q;
  assign if_inst          = if_inst_q;
  assign mem_fetch_enable = fetch_en_q;
  assign mem_addr         = mem_addr_q;

endmodule
